arc4_sched: RTL
===============

// Module: arc4_sched
// PURPOSE
//  Top-level sequencer and S-memory arbiter for one ARC4 crack attempt.
//  - On a start handshake, runs the init, ksa and prga engines in order through
//    each engine's en/rdy handshake.
//  - Grants the single 256x8 S-memory port to exactly one engine at a time.
//  - Reports done, plus a sticky error for illegal writes and watchdog expiry.
// PARAMETERS
//  ADDR_W    8  S-memory address width (256 entries)
//  DATA_W    8  S-memory data width
//  WDOG_CYC  0  max cycles per engine phase before error; 0 = watchdog disabled
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst          in   1       asynchronous, active-high reset
//  en           in   1       start request; accepted only when rdy=1
//  rdy          out  1       1 in IDLE or DONE (can accept en)
//  done         out  1       1 in DONE; cleared by next accepted en or rst
//  err          out  1       sticky; cleared only by rst or an accepted en
//  phase        out  2       0=none, 1=init, 2=ksa, 3=prga (current owner)
//  init_en      out  1       engine start pulse (same for ksa_/prga_)
//  init_rdy     in   1       engine ready
//  init_addr    in   ADDR_W  engine S-memory address
//  init_wrdata  in   DATA_W  engine write data
//  init_wren    in   1       engine write enable
//  ksa_*, prga_*             same five signals as init_*, per engine
//  s_addr       out  ADDR_W  to S-memory
//  s_wrdata     out  DATA_W  to S-memory
//  s_wren       out  1       to S-memory
//  s_rddata     in   DATA_W  from S-memory; wired unregistered to all engines
//  init_rddata / ksa_rddata / prga_rddata  out  DATA_W  = s_rddata
// BEHAVIOUR
//  Reset: state=IDLE; owner=none; rdy=1; done=0; err=0; all *_en=0; s_wren=0;
//   s_addr=0; s_wrdata=0. Outputs reach these values asynchronously on rst.
//  Engines are not reset by this block. Top ties their rst_n to ~rst.
//  FSM: IDLE, I_GO, I_RUN, I_WAIT, K_GO, K_RUN, K_WAIT, P_GO, P_RUN, P_WAIT, DONE.
//   IDLE/DONE: en=1 -> I_GO next cycle. In the same edge, done<=0 and err<=0.
//   X_GO: owner=X. Wait for x_rdy=1. Then x_en=1 for exactly that one cycle
//    (Moore output of X_GO gated by x_rdy) -> X_RUN.
//   X_RUN: wait for x_rdy=0 (engine has taken the start) -> X_WAIT.
//    If x_rdy stays 1 for 2 cycles, the engine has finished in zero time ->
//    next phase.
//   X_WAIT: x_rdy=1 -> next phase GO state (I->K, K->P, P->DONE).
//  Grant: owner comes from the registered state.
//   - Owner's addr/wrdata/wren are driven combinationally to s_*; no added latency.
//   - With no owner (IDLE, DONE), s_wren=0.
//   - Owner changes only on phase transitions. No engine overlap, no write
//     hazard across phases.
//  Illegal write: any non-owner *_wren=1 sets err. That write is never forwarded.
//  en while rdy=0: ignored. Not queued.
//  Watchdog:
//   - A counter clears on entry to each X_GO.
//   - It saturates at WDOG_CYC; reaching it sets err and forces DONE.
//   - A phase of exactly WDOG_CYC-1 cycles passes.
//   - Counter width is $clog2(WDOG_CYC+1), min 1.
//  rst mid-phase: immediate return to IDLE. The current x_en drops the same
//   instant, and the S-memory port is released (s_wren=0).
// STRUCTURE
//  Package arc4_pkg:
//   - typedef enum logic[3:0] sched_state_t
//   - typedef enum logic[1:0] owner_t {OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA}
//   - localparam S_DEPTH = 256
//  Sub-module arc4_mem_mux: combinational 3:1 port mux plus illegal-write
//   detect, selected by owner_t. Everything else is in arc4_sched.
// TESTING
//  1 Reset: rst pulse -> rdy=1, done=0, err=0, phase=0, s_wren=0, all *_en=0.
//  2 Full run: behavioural engines of 256/768/32 cycles; en=1 for 1 cycle ->
//    init_en, ksa_en and prga_en each pulse once, in order.
//    phase goes 1,2,3, then done=1 after ~1060 cycles. err=0.
//  3 Arbitration: during ksa, init_wren=1 with addr=8'h10 -> s_wren reflects
//    ksa_wren only, and err=1 next cycle.
//    Memory model shows S[0x10] unchanged by init.
//  4 Handshake edges: init_rdy held 0 for 5 cycles in I_GO -> init_en stays 0,
//    then pulses 1 cycle. en=1 during K_WAIT -> ignored, with no restart.
//  5 Watchdog: WDOG_CYC=100, ksa never reasserts rdy -> err=1 and done=1
//    at cycle 100 of the ksa phase. prga_en never asserts.
//  6 Reset mid-run: rst at cycle 300 (ksa) -> ksa_en=0, s_wren=0, IDLE.
//    A following en restarts from init, and the run completes with done=1.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 scheduler types: sequencer states, S-memory owner encoding and memory geometry.
// Pure declarations; no logic, no latency.
package arc4_pkg;

    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = $clog2(S_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_I_GO,
        ST_I_RUN,
        ST_I_WAIT,
        ST_K_GO,
        ST_K_RUN,
        ST_K_WAIT,
        ST_P_GO,
        ST_P_RUN,
        ST_P_WAIT,
        ST_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_PRGA
    } owner_t;

    function automatic owner_t state_owner(input sched_state_t s);
        case (s)
            ST_I_GO, ST_I_RUN, ST_I_WAIT: return OWN_INIT;
            ST_K_GO, ST_K_RUN, ST_K_WAIT: return OWN_KSA;
            ST_P_GO, ST_P_RUN, ST_P_WAIT: return OWN_PRGA;
            default:                      return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arc4_mem_mux.sv
// 3:1 S-memory port mux selected by owner, plus detection of writes from non-owners.
// Purely combinational, zero latency; non-owner writes are dropped and flagged.
module arc4_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = S_ADDR_W,
    parameter int DATA_W = 8
) (
    input  owner_t            owner_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [DATA_W-1:0] init_wrdata_i,
    input  logic              init_wren_i,
    input  logic [ADDR_W-1:0] ksa_addr_i,
    input  logic [DATA_W-1:0] ksa_wrdata_i,
    input  logic              ksa_wren_i,
    input  logic [ADDR_W-1:0] prga_addr_i,
    input  logic [DATA_W-1:0] prga_wrdata_i,
    input  logic              prga_wren_i,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wrdata_o,
    output logic              s_wren_o,
    output logic              illegal_o
);

    always_comb begin
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (owner_i)
            OWN_INIT: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            OWN_KSA: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            OWN_PRGA: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: ;
        endcase
    end

    assign illegal_o = (init_wren_i && (owner_i != OWN_INIT)) ||
                       (ksa_wren_i  && (owner_i != OWN_KSA))  ||
                       (prga_wren_i && (owner_i != OWN_PRGA));

endmodule

// File: rtl/arc4_sched.sv
// Sequences init -> ksa -> prga over their en/rdy handshakes and grants the single S-memory port.
// Port mux adds no latency; en is only taken while rdy=1 and is otherwise dropped.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int ADDR_W   = S_ADDR_W,
    parameter int DATA_W   = 8,
    parameter int WDOG_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_en,
    input  logic              init_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    output logic [DATA_W-1:0] init_rddata,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    output logic [DATA_W-1:0] ksa_rddata,
    output logic              prga_en,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [DATA_W-1:0] prga_rddata,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rddata
);

    localparam int              WD_W   = (WDOG_CYC < 1) ? 1 : $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYC);

    sched_state_t    state_q, state_d;
    logic            err_q, err_d;
    logic            seen_q, seen_d;
    logic [WD_W-1:0] wd_q, wd_d;
    owner_t          owner;
    logic            illegal;
    logic            enter_go;

    assign owner = state_owner(state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            wd_q    <= wd_d;
        end
    end

    // seen_q marks a RUN cycle with rdy still high; a second one means a zero-time engine.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        seen_d   = 1'b0;
        wd_d     = wd_q;
        enter_go = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (en) state_d = ST_I_GO;
            ST_I_GO:   if (init_rdy) state_d = ST_I_RUN;
            ST_I_RUN:  if (!init_rdy) state_d = ST_I_WAIT;
                       else if (seen_q) state_d = ST_K_GO;
                       else seen_d = 1'b1;
            ST_I_WAIT: if (init_rdy) state_d = ST_K_GO;
            ST_K_GO:   if (ksa_rdy) state_d = ST_K_RUN;
            ST_K_RUN:  if (!ksa_rdy) state_d = ST_K_WAIT;
                       else if (seen_q) state_d = ST_P_GO;
                       else seen_d = 1'b1;
            ST_K_WAIT: if (ksa_rdy) state_d = ST_P_GO;
            ST_P_GO:   if (prga_rdy) state_d = ST_P_RUN;
            ST_P_RUN:  if (!prga_rdy) state_d = ST_P_WAIT;
                       else if (seen_q) state_d = ST_DONE;
                       else seen_d = 1'b1;
            ST_P_WAIT: if (prga_rdy) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase

        // Watchdog outranks a phase completing on the very cycle the limit is reached.
        if (owner != OWN_NONE) begin
            if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
            if ((WDOG_CYC != 0) && (wd_d == WD_MAX)) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end
        end

        if (illegal) err_d = 1'b1;
        if (rdy && en) err_d = 1'b0;

        enter_go = (state_d != state_q) &&
                   ((state_d == ST_I_GO) || (state_d == ST_K_GO) || (state_d == ST_P_GO));
        if (enter_go) wd_d = '0;
        if (state_d == ST_DONE) seen_d = 1'b0;
    end

    assign rdy     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign phase   = owner;
    assign init_en = (state_q == ST_I_GO) && init_rdy;
    assign ksa_en  = (state_q == ST_K_GO) && ksa_rdy;
    assign prga_en = (state_q == ST_P_GO) && prga_rdy;

    assign init_rddata = s_rddata;
    assign ksa_rddata  = s_rddata;
    assign prga_rddata = s_rddata;

    arc4_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .owner_i       (owner),
        .init_addr_i   (init_addr),
        .init_wrdata_i (init_wrdata),
        .init_wren_i   (init_wren),
        .ksa_addr_i    (ksa_addr),
        .ksa_wrdata_i  (ksa_wrdata),
        .ksa_wren_i    (ksa_wren),
        .prga_addr_i   (prga_addr),
        .prga_wrdata_i (prga_wrdata),
        .prga_wren_i   (prga_wren),
        .s_addr_o      (s_addr),
        .s_wrdata_o    (s_wrdata),
        .s_wren_o      (s_wren),
        .illegal_o     (illegal)
    );

endmodule
